// File: rtl/piradip_axilite_master_if.sv
// AXI4-Lite bundle between the piradip command-driven initiator and a register-file responder.
interface piradip_axilite_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/piradip_axilite_master.sv
// Single-outstanding AXI4-Lite initiator: takes one read/write command, runs the
// AXI channel handshakes, and returns data/response on a valid/ready response port.
module piradip_axilite_master #(
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  piradip_axilite_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic                    aw_done, w_done;
  logic                    accept, aw_hs, w_hs;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = axi.awvalid && axi.awready;
  assign w_hs   = axi.wvalid && axi.wready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = WR_RESP;
      WR_RESP: if (axi.bvalid) next_state = RSP;
      RD_REQ:  if (axi.arready) next_state = RD_DATA;
      RD_DATA: if (axi.rvalid) next_state = RSP;
      RSP:     if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Valids are decoded from registered state only, so they cannot glitch or drop early.
  always_comb begin
    cmd_ready   = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE:    cmd_ready   = !areset;
      WR_REQ: begin
        axi.awvalid = !aw_done;
        axi.wvalid  = !w_done;
      end
      WR_RESP: axi.bready  = 1'b1;
      RD_REQ:  axi.arvalid = 1'b1;
      RD_DATA: axi.rready  = 1'b1;
      RSP:     rsp_valid   = 1'b1;
      default: ;
    endcase
  end

  // NOTE: these are a handful of datapath flops, not a memory array, so they take the async reset too.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        rdata_q <= '0;
        resp_q  <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state == WR_RESP && axi.bvalid) resp_q <= axi.bresp;
      if (state == RD_DATA && axi.rvalid) begin
        rdata_q <= axi.rdata;
        resp_q  <= axi.rresp;
      end
    end
  end

  assign axi.awaddr = addr_q;
  assign axi.awprot = PROT;
  assign axi.wdata  = wdata_q;
  assign axi.wstrb  = wstrb_q;
  assign axi.araddr = addr_q;
  assign axi.arprot = PROT;

  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule
